// File: rtl/baby_control_pkg.sv
// Shared types and default sizes for the SSEM ("Baby") instruction sequencer.
package baby_pkg;

    localparam int BABY_WORD_W   = 32;
    localparam int BABY_ADDR_W   = 5;
    localparam int BABY_FUNC_LSB = 13;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC
    } state_t;

    // SUB has two encodings because the Baby ignored the top function bit for it.
    typedef enum logic [2:0] {
        F_JMP  = 3'd0,
        F_SUB  = 3'd1,
        F_LDN  = 3'd2,
        F_CMP  = 3'd3,
        F_JRP  = 3'd4,
        F_SUB2 = 3'd5,
        F_STO  = 3'd6,
        F_STP  = 3'd7
    } func_t;

endpackage

// File: rtl/baby_control_if.sv
// Store port between the sequencer (master) and the 32x32 store (slave).
interface baby_control_if #(
    parameter int WORD_W = baby_pkg::BABY_WORD_W,
    parameter int ADDR_W = baby_pkg::BABY_ADDR_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/baby_control_alu.sv
// Combinational execute stage: next accumulator and next CI for one Baby instruction.
module baby_alu
    import baby_pkg::*;
#(
    parameter int WORD_W = BABY_WORD_W
) (
    input  logic [WORD_W-1:0] acc,
    input  logic [WORD_W-1:0] s,
    input  logic [WORD_W-1:0] ci,
    input  func_t             f,
    output logic [WORD_W-1:0] next_acc,
    output logic [WORD_W-1:0] next_ci
);

    // STO and STP leave both registers alone; their effects live in the sequencer.
    always_comb begin
        next_acc = acc;
        next_ci  = ci;
        case (f)
            F_JMP:         next_ci  = s;
            F_JRP:         next_ci  = ci + s;
            F_LDN:         next_acc = '0 - s;
            F_SUB, F_SUB2: next_acc = acc - s;
            F_CMP: begin
                if (acc[WORD_W-1]) begin
                    next_ci = ci + WORD_W'(1);
                end
            end
            default: begin
                next_acc = acc;
                next_ci  = ci;
            end
        endcase
    end

endmodule

// File: rtl/baby_control.sv
// SSEM instruction-cycle sequencer: one enable strobe runs fetch, decode, operand read and execute.
module baby_control
    import baby_pkg::*;
#(
    parameter int WORD_W   = BABY_WORD_W,
    parameter int ADDR_W   = BABY_ADDR_W,
    parameter int FUNC_LSB = BABY_FUNC_LSB
) (
    input  logic               CLOCK_40,
    input  logic               reset,
    input  logic               enable,
    baby_control_if.master     mem,
    output logic [WORD_W-1:0]  acc,
    output logic [WORD_W-1:0]  ci,
    output logic [WORD_W-1:0]  pi,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               overrun
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] wdata_d;
    logic              rd_q;
    logic              rd_d;
    logic              wr_q;
    logic              wr_d;
    logic [WORD_W-1:0] acc_d;
    logic [WORD_W-1:0] ci_d;
    logic [WORD_W-1:0] pi_d;
    logic              busy_d;
    logic              done_d;
    logic              halted_d;
    logic              overrun_d;
    logic [WORD_W-1:0] ci_inc;
    logic [WORD_W-1:0] alu_acc;
    logic [WORD_W-1:0] alu_ci;
    func_t             decode_func;
    func_t             exec_func;

    assign ci_inc      = ci + WORD_W'(1);
    assign decode_func = func_t'(mem.mem_rdata[FUNC_LSB +: 3]);
    assign exec_func   = func_t'(pi[FUNC_LSB +: 3]);

    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd    = rd_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_wdata = wdata_q;

    baby_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .acc      (acc),
        .s        (mem.mem_rdata),
        .ci       (ci),
        .f        (exec_func),
        .next_acc (alu_acc),
        .next_ci  (alu_ci)
    );

    // Every output is a register; this block only decides what each one loads next.
    // Store-port values chosen in one state are presented to the store in the following state.
    always_comb begin
        next_state = state;
        acc_d      = acc;
        ci_d       = ci;
        pi_d       = pi;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy;
        halted_d   = halted;
        overrun_d  = overrun | (enable & (state != IDLE));

        case (state)
            IDLE: begin
                if (enable && !halted) begin
                    next_state = FETCH;
                    busy_d     = 1'b1;
                end
            end
            FETCH: begin
                ci_d       = ci_inc;
                addr_d     = ci_inc[ADDR_W-1:0];
                rd_d       = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                pi_d   = mem.mem_rdata;
                addr_d = mem.mem_rdata[ADDR_W-1:0];
                // STO swaps the operand read for the write so the port never reads and writes at once.
                if (decode_func == F_STO) begin
                    wr_d    = 1'b1;
                    wdata_d = acc;
                end else begin
                    rd_d = 1'b1;
                end
                done_d     = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                acc_d      = alu_acc;
                ci_d       = alu_ci;
                halted_d   = halted | (exec_func == F_STP);
                busy_d     = 1'b0;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_40) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            ci      <= '0;
            pi      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            halted  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= next_state;
            acc     <= acc_d;
            ci      <= ci_d;
            pi      <= pi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy    <= busy_d;
            done    <= done_d;
            halted  <= halted_d;
            overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_baby_control.sv
// Scoreboard bench for baby_control: an instruction-level Baby model predicts each done.
module tb_baby_control;

    logic        CLOCK_40;
    logic        reset;
    logic        enable;
    logic [31:0] acc;
    logic [31:0] ci;
    logic [31:0] pi;
    logic        busy;
    logic        done;
    logic        halted;
    logic        overrun;

    baby_control_if mem_bus ();

    baby_control dut (
        .CLOCK_40 (CLOCK_40),
        .reset    (reset),
        .enable   (enable),
        .mem      (mem_bus.master),
        .acc      (acc),
        .ci       (ci),
        .pi       (pi),
        .busy     (busy),
        .done     (done),
        .halted   (halted),
        .overrun  (overrun)
    );

    typedef struct {
        logic [31:0] acc;
        logic [31:0] ci;
        logic        halted;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ram[32];
    logic [31:0] image[32];
    logic        load_img;
    logic [31:0] ref_mem[32];
    logic [31:0] ref_acc;
    logic [31:0] ref_ci;
    logic        ref_halted;
    int          vectors;
    int          miscompares;

    initial CLOCK_40 = 1'b0;
    always #5 CLOCK_40 = ~CLOCK_40;

    // Store: asynchronous read of the registered address, write on the edge.
    assign mem_bus.mem_rdata = ram[mem_bus.mem_addr];

    always @(posedge CLOCK_40) begin
        if (load_img) begin
            for (int i = 0; i < 32; i++) ram[i] <= image[i];
        end else if (mem_bus.mem_wr) begin
            ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        end
    end

    function automatic logic [31:0] instr(input logic [2:0] f, input logic [4:0] line);
        return {16'h0, f, 8'h0, line};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Executes one whole instruction the way the Baby programmer's manual describes it.
    task automatic model_step();
        exp_t        e;
        logic [31:0] w;
        logic [31:0] s;
        logic [4:0]  line;
        if (ref_halted) return;
        ref_ci  = ref_ci + 32'd1;
        w       = ref_mem[ref_ci[4:0]];
        line    = w[4:0];
        s       = ref_mem[line];
        e.wr    = 1'b0;
        e.waddr = line;
        e.wdata = ref_acc;
        case (w[15:13])
            3'd0: ref_ci = s;
            3'd4: ref_ci = ref_ci + s;
            3'd2: ref_acc = 32'd0 - s;
            3'd1, 3'd5: ref_acc = ref_acc - s;
            3'd3: if ($signed(ref_acc) < 0) ref_ci = ref_ci + 32'd1;
            3'd6: begin
                e.wr          = 1'b1;
                ref_mem[line] = ref_acc;
            end
            default: ref_halted = 1'b1;
        endcase
        e.acc    = ref_acc;
        e.ci     = ref_ci;
        e.halted = ref_halted;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_40); #1;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_40);
        #1;
        reset      = 1'b0;
        ref_acc    = '0;
        ref_ci     = '0;
        ref_halted = 1'b0;
    endtask

    task automatic load_image();
        @(posedge CLOCK_40); #1;
        load_img = 1'b1;
        @(posedge CLOCK_40); #1;
        load_img = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = image[i];
    endtask

    task automatic clear_image();
        for (int i = 0; i < 32; i++) image[i] = '0;
    endtask

    task automatic applyStimulus(input int gap);
        @(posedge CLOCK_40); #1;
        enable = 1'b1;
        model_step();
        @(posedge CLOCK_40); #1;
        enable = 1'b0;
        repeat (gap - 1) @(posedge CLOCK_40);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK_40);
            if (mem_bus.mem_rd && mem_bus.mem_wr)
                checkOutput("rd_wr_exclusive", 32'(mem_bus.mem_wr), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("exec_mem_wr", 32'(mem_bus.mem_wr), 32'(e.wr));
                    if (e.wr) begin
                        checkOutput("sto_addr", 32'(mem_bus.mem_addr), 32'(e.waddr));
                        checkOutput("sto_wdata", mem_bus.mem_wdata, e.wdata);
                    end
                    @(negedge CLOCK_40);
                    checkOutput("acc", acc, e.acc);
                    checkOutput("ci", ci, e.ci);
                    checkOutput("halted", 32'(halted), 32'(e.halted));
                    checkOutput("done_one_cycle", 32'(done), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        int activity;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        load_img    = 1'b0;

        // Reset values.
        repeat (2) @(posedge CLOCK_40);
        #1;
        checkOutput("reset_acc", acc, 32'd0);
        checkOutput("reset_ci", ci, 32'd0);
        checkOutput("reset_pi", pi, 32'd0);
        checkOutput("reset_flags", {26'd0, busy, done, halted, overrun, mem_bus.mem_rd, mem_bus.mem_wr}, 32'd0);
        checkOutput("reset_mem_port", {27'd0, mem_bus.mem_addr} | mem_bus.mem_wdata, 32'd0);

        // LDN 5 with line 5 = 7 from a fresh reset.
        clear_image();
        image[1] = instr(3'd2, 5'd5);
        image[5] = 32'd7;
        do_reset();
        load_image();
        applyStimulus(8);
        checkOutput("ldn_acc", acc, 32'hFFFF_FFF9);
        checkOutput("ldn_ci", ci, 32'd1);

        // Directed program touching every function code.
        clear_image();
        image[1]  = instr(3'd2, 5'd11);
        image[2]  = instr(3'd1, 5'd12);
        image[3]  = instr(3'd6, 5'd20);
        image[4]  = instr(3'd3, 5'd0);
        image[5]  = instr(3'd2, 5'd9);
        image[6]  = instr(3'd3, 5'd0);
        image[7]  = instr(3'd0, 5'd14);
        image[8]  = instr(3'd4, 5'd13);
        image[9]  = 32'd1;
        image[10] = instr(3'd7, 5'd0);
        image[11] = 32'hFFFF_FFF6;
        image[12] = 32'd3;
        image[13] = 32'hFFFF_FFFE;
        image[14] = 32'd9;
        do_reset();
        load_image();
        repeat (9) applyStimulus(8);
        checkOutput("prog_sto_ram20", ram[20], 32'd7);
        checkOutput("prog_halted", 32'(halted), 32'd1);
        checkOutput("prog_ci", ci, 32'd10);
        checkOutput("prog_acc", acc, 32'hFFFF_FFFF);

        // Enables while halted must be ignored entirely.
        activity = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLOCK_40); #1;
            enable = 1'b1;
            @(posedge CLOCK_40); #1;
            enable = 1'b0;
            for (int c = 0; c < 7; c++) begin
                @(negedge CLOCK_40);
                if (mem_bus.mem_rd || busy) activity++;
            end
        end
        checkOutput("halted_activity", 32'(activity), 32'd0);
        checkOutput("halted_overrun", 32'(overrun), 32'd0);

        // CI wraps from all-ones to zero and fetches line 0.
        clear_image();
        image[0] = instr(3'd2, 5'd3);
        image[1] = instr(3'd0, 5'd2);
        image[2] = 32'hFFFF_FFFF;
        image[3] = 32'd5;
        do_reset();
        load_image();
        applyStimulus(8);
        checkOutput("wrap_jmp_ci", ci, 32'hFFFF_FFFF);
        applyStimulus(8);
        checkOutput("wrap_ci", ci, 32'd0);
        checkOutput("wrap_acc", acc, 32'hFFFF_FFFB);

        // Extra enables in DECODE and EXEC are dropped and flag overrun.
        clear_image();
        image[1] = instr(3'd2, 5'd5);
        image[5] = 32'd7;
        do_reset();
        load_image();
        @(posedge CLOCK_40); #1;
        enable = 1'b1;
        model_step();
        @(posedge CLOCK_40); #1;
        enable = 1'b0;
        @(posedge CLOCK_40); #1;
        enable = 1'b1;
        repeat (2) @(posedge CLOCK_40);
        #1;
        enable = 1'b0;
        repeat (8) @(posedge CLOCK_40);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        checkOutput("overrun_ci", ci, 32'd1);
        checkOutput("overrun_acc", acc, 32'hFFFF_FFF9);

        // Reset while a STO is in DECODE: nothing is written.
        clear_image();
        image[1]  = instr(3'd6, 5'd20);
        image[20] = 32'h0000_1234;
        do_reset();
        load_image();
        @(posedge CLOCK_40); #1;
        enable = 1'b1;
        @(posedge CLOCK_40); #1;
        enable = 1'b0;
        @(posedge CLOCK_40); #1;
        checkOutput("decode_rd", 32'(mem_bus.mem_rd), 32'd1);
        checkOutput("decode_addr", 32'(mem_bus.mem_addr), 32'd1);
        reset = 1'b1;
        @(posedge CLOCK_40); #1;
        checkOutput("midreset_flags", {26'd0, busy, done, halted, overrun, mem_bus.mem_rd, mem_bus.mem_wr}, 32'd0);
        checkOutput("midreset_ci_pi", ci | pi | {27'd0, mem_bus.mem_addr}, 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge CLOCK_40);
        #1;
        checkOutput("midreset_no_write", ram[20], 32'h0000_1234);

        // Random programs: every word is both a potential instruction and operand.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                image[i] = $urandom;
                if (image[i][15:13] == 3'd7 && $urandom_range(0, 3) != 0)
                    image[i][15:13] = 3'($urandom_range(0, 6));
            end
            do_reset();
            load_image();
            for (int n = 0; n < 20; n++) applyStimulus(int'($urandom_range(6, 9)));
            repeat (4) @(posedge CLOCK_40);
            #1;
            checkOutput("random_overrun", 32'(overrun), 32'd0);
            for (int i = 0; i < 32; i++) checkOutput("random_store", ram[i], ref_mem[i]);
        end

        repeat (10) @(posedge CLOCK_40);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
